// File: rtl/mm_operand_loader.sv
// Serial-to-parallel operand loader for the 10x20 * 20x10 matrix-multiply/bias/clamp block.
// Packs a valid/ready word stream into image, weight and bias buses, then holds them until acknowledged.
module mm_operand_loader #(
  parameter int unsigned W          = 30,
  parameter int unsigned IMG_WORDS  = 200,
  parameter int unsigned WGT_WORDS  = 200,
  parameter int unsigned BIAS_WORDS = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [W-1:0]                in_data,
  output logic [W*IMG_WORDS-1:0]      image,
  output logic [W*WGT_WORDS-1:0]      weight,
  output logic [W*BIAS_WORDS-1:0]     Bias,
  output logic                        operands_valid,
  input  logic                        out_ack,
  output logic [1:0]                  phase,
  output logic [7:0]                  word_cnt
);

  typedef enum logic [1:0] {
    LOAD_IMG  = 2'd0,
    LOAD_WGT  = 2'd1,
    LOAD_BIAS = 2'd2,
    HOLD      = 2'd3
  } state_t;

  localparam logic [7:0] IMG_LAST  = 8'(IMG_WORDS - 1);
  localparam logic [7:0] WGT_LAST  = 8'(WGT_WORDS - 1);
  localparam logic [7:0] BIAS_LAST = 8'(BIAS_WORDS - 1);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [7:0]                r_cnt;
  logic [7:0]                w_next_cnt;
  logic                      r_valid;
  logic                      w_next_valid;
  logic                      w_ready;
  logic                      w_xfer;
  logic [W*IMG_WORDS-1:0]    r_image;
  logic [W*WGT_WORDS-1:0]    r_weight;
  logic [W*BIAS_WORDS-1:0]   r_bias;

  // Ready depends only on state and reset, never on in_valid.
  assign w_ready = (r_state != HOLD) && !rst;
  assign w_xfer  = in_valid && w_ready;

  // Next-state, count and valid decode.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_valid = r_valid;
    case (r_state)
      LOAD_IMG: begin
        if (w_xfer) begin
          if (r_cnt == IMG_LAST) begin
            w_next_cnt   = 8'd0;
            w_next_state = LOAD_WGT;
          end else begin
            w_next_cnt = r_cnt + 8'd1;
          end
        end else begin
          w_next_cnt = r_cnt;
        end
      end
      LOAD_WGT: begin
        if (w_xfer) begin
          if (r_cnt == WGT_LAST) begin
            w_next_cnt   = 8'd0;
            w_next_state = LOAD_BIAS;
          end else begin
            w_next_cnt = r_cnt + 8'd1;
          end
        end else begin
          w_next_cnt = r_cnt;
        end
      end
      LOAD_BIAS: begin
        if (w_xfer) begin
          if (r_cnt == BIAS_LAST) begin
            w_next_cnt   = 8'd0;
            w_next_state = HOLD;
            w_next_valid = 1'b1;
          end else begin
            w_next_cnt = r_cnt + 8'd1;
          end
        end else begin
          w_next_cnt = r_cnt;
        end
      end
      HOLD: begin
        if (out_ack) begin
          w_next_state = LOAD_IMG;
          w_next_valid = 1'b0;
        end else begin
          w_next_state = HOLD;
        end
      end
      default: begin
        w_next_state = LOAD_IMG;
        w_next_cnt   = 8'd0;
        w_next_valid = 1'b0;
      end
    endcase
  end

  // State, count and valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD_IMG;
      r_cnt   <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_valid <= w_next_valid;
    end
  end

  // Operand buses: the active bus shifts left so the first word of a phase ends at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_image  <= '0;
      r_weight <= '0;
      r_bias   <= '0;
    end else if (w_xfer) begin
      case (r_state)
        LOAD_IMG:  r_image  <= {r_image[W*IMG_WORDS-W-1:0], in_data};
        LOAD_WGT:  r_weight <= {r_weight[W*WGT_WORDS-W-1:0], in_data};
        LOAD_BIAS: r_bias   <= {r_bias[W*BIAS_WORDS-W-1:0], in_data};
        default:   r_image  <= r_image;
      endcase
    end
  end

  assign in_ready       = w_ready;
  assign image          = r_image;
  assign weight         = r_weight;
  assign Bias           = r_bias;
  assign operands_valid = r_valid;
  assign phase          = r_state;
  assign word_cnt       = r_cnt;

endmodule

// File: tb/tb_mm_operand_loader.sv
// Scoreboard bench for mm_operand_loader: expected operand sets are queued as loads are driven
// and compared when operands_valid is raised.
module tb_mm_operand_loader;

  localparam int W     = 30;
  localparam int NIMG  = 200;
  localparam int NWGT  = 200;
  localparam int NBIAS = 10;
  localparam int NALL  = NIMG + NWGT + NBIAS;

  typedef struct {
    logic [W*NIMG-1:0]  img;
    logic [W*NWGT-1:0]  wgt;
    logic [W*NBIAS-1:0] bias;
  } set_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [W-1:0]         in_data = '0;
  logic [W*NIMG-1:0]    image;
  logic [W*NWGT-1:0]    weight;
  logic [W*NBIAS-1:0]   Bias;
  logic                 operands_valid;
  logic                 out_ack = 1'b0;
  logic [1:0]           phase;
  logic [7:0]           word_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  set_t sb_q[$];
  set_t last_set;

  mm_operand_loader #(.W(W), .IMG_WORDS(NIMG), .WGT_WORDS(NWGT), .BIAS_WORDS(NBIAS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .image(image), .weight(weight), .Bias(Bias), .operands_valid(operands_valid),
    .out_ack(out_ack), .phase(phase), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_of(input int mode, input int k);
    if (mode == 0) return W'(k + 1);
    return W'(7);
  endfunction

  // Element k of the stream lands at field index (N-1-local_index) counted from the LSB.
  function automatic set_t make_set(input int mode);
    set_t s;
    s.img = '0; s.wgt = '0; s.bias = '0;
    for (int k = 0; k < NALL; k++) begin
      if (k < NIMG)             s.img[W*(NIMG-1-k) +: W]              = word_of(mode, k);
      else if (k < NIMG + NWGT) s.wgt[W*(NWGT-1-(k-NIMG)) +: W]       = word_of(mode, k);
      else                      s.bias[W*(NBIAS-1-(k-NIMG-NWGT)) +: W] = word_of(mode, k);
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive words first_k .. first_k+n-1 and check phase/count/valid against a count-based model.
  task automatic load_words(input int mode, input bit gaps, input int first_k, input int n);
    int k = first_k;
    int cycles = 0;
    logic [1:0] e_ph;
    logic [7:0] e_cnt;
    bit xfer;
    while (k < first_k + n && cycles < 4000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? word_of(mode, k) : W'($urandom);
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_load k=%0d got=%b want=1", k, in_ready); end
      xfer = in_valid;
      step();
      cycles++;
      if (xfer) k++;
      if (k < NIMG)              begin e_ph = 2'd0; e_cnt = 8'(k); end
      else if (k < NIMG + NWGT)  begin e_ph = 2'd1; e_cnt = 8'(k - NIMG); end
      else if (k < NALL)         begin e_ph = 2'd2; e_cnt = 8'(k - NIMG - NWGT); end
      else                       begin e_ph = 2'd3; e_cnt = 8'd0; end
      n_vec++;
      if (phase !== e_ph || word_cnt !== e_cnt) begin
        n_err++; $display("FAIL count k=%0d phase=%0d cnt=%0d want phase=%0d cnt=%0d", k, phase, word_cnt, e_ph, e_cnt);
      end
      n_vec++;
      if (operands_valid !== (k == NALL)) begin
        n_err++; $display("FAIL valid_timing k=%0d got=%b want=%b", k, operands_valid, (k == NALL));
      end
    end
    in_valid = 1'b0;
    if (k < first_k + n) begin
      n_vec++; n_err++; $display("FAIL load_timeout accepted=%0d want=%0d", k - first_k, n);
    end
  endtask

  task automatic check_set();
    set_t e;
    n_vec++;
    if (operands_valid !== 1'b1 || phase !== 2'd3) begin
      n_err++; $display("FAIL set_ready valid=%b phase=%0d want valid=1 phase=3", operands_valid, phase);
    end
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++; $display("FAIL scoreboard_empty got=0 entries want>=1");
      return;
    end
    e = sb_q.pop_front();
    last_set = e;
    for (int i = 0; i < NIMG; i++)
      if (image[W*i +: W] !== e.img[W*i +: W]) begin
        n_err++; $display("FAIL image_field idx=%0d got=%0d want=%0d", i, image[W*i +: W], e.img[W*i +: W]); break;
      end
    n_vec++;
    for (int i = 0; i < NWGT; i++)
      if (weight[W*i +: W] !== e.wgt[W*i +: W]) begin
        n_err++; $display("FAIL weight_field idx=%0d got=%0d want=%0d", i, weight[W*i +: W], e.wgt[W*i +: W]); break;
      end
    n_vec++;
    for (int i = 0; i < NBIAS; i++)
      if (Bias[W*i +: W] !== e.bias[W*i +: W]) begin
        n_err++; $display("FAIL bias_field idx=%0d got=%0d want=%0d", i, Bias[W*i +: W], e.bias[W*i +: W]); break;
      end
  endtask

  task automatic pulse_ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", in_ready); end
    step(); step();
    n_vec++;
    if (image !== '0 || weight !== '0 || Bias !== '0 || operands_valid !== 1'b0 ||
        phase !== 2'd0 || word_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_state valid=%b phase=%0d cnt=%0d want 0 0 0", operands_valid, phase, word_cnt);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
  endtask

  task automatic test_ramp();
    sb_q.push_back(make_set(0));
    load_words(0, 1'b0, 0, NALL);
    n_vec++;
    if (image[5999:5970] !== 30'd1 || image[29:0] !== 30'd200 || weight[5999:5970] !== 30'd201 ||
        weight[29:0] !== 30'd400 || Bias[299:270] !== 30'd401 || Bias[29:0] !== 30'd410) begin
      n_err++; $display("FAIL ramp_ends img=%0d/%0d wgt=%0d/%0d bias=%0d/%0d want 1/200 201/400 401/410",
        image[5999:5970], image[29:0], weight[5999:5970], weight[29:0], Bias[299:270], Bias[29:0]);
    end
    check_set();
  endtask

  task automatic test_hold_backpressure();
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_data = 30'h3FFFFFFF;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready cyc=%0d got=%b want=0", c, in_ready); end
      step();
      n_vec++;
      if (operands_valid !== 1'b1 || image !== last_set.img || weight !== last_set.wgt || Bias !== last_set.bias) begin
        n_err++; $display("FAIL hold_stable cyc=%0d valid=%b want=1 buses unchanged", c, operands_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ack_rearm();
    pulse_ack();
    n_vec++;
    if (operands_valid !== 1'b0 || phase !== 2'd0 || in_ready !== 1'b1 || word_cnt !== 8'd0) begin
      n_err++; $display("FAIL ack_rearm valid=%b phase=%0d ready=%b cnt=%0d want 0 0 1 0",
        operands_valid, phase, in_ready, word_cnt);
    end
    sb_q.push_back(make_set(1));
    load_words(1, 1'b0, 0, NALL);
    check_set();
  endtask

  task automatic test_gaps();
    pulse_ack();
    sb_q.push_back(make_set(0));
    load_words(0, 1'b1, 0, NALL);
    check_set();
  endtask

  task automatic test_stray_ack();
    pulse_ack();
    load_words(0, 1'b0, 0, 5);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    n_vec++;
    if (phase !== 2'd0 || word_cnt !== 8'd5 || operands_valid !== 1'b0) begin
      n_err++; $display("FAIL stray_ack phase=%0d cnt=%0d valid=%b want 0 5 0", phase, word_cnt, operands_valid);
    end
  endtask

  task automatic test_reset_midload();
    load_words(0, 1'b0, 5, NIMG + 150 - 5);
    n_vec++;
    if (phase !== 2'd1 || word_cnt !== 8'd150) begin
      n_err++; $display("FAIL midload_pos phase=%0d cnt=%0d want 1 150", phase, word_cnt);
    end
    test_reset();
    sb_q.push_back(make_set(0));
    load_words(0, 1'b0, 0, NALL);
    check_set();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_hold_backpressure();
    test_ack_rearm();
    test_gaps();
    test_stray_ack();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
